// File: rtl/udp_rx_pkg.sv
// udp_rx_pkg: shared types and constants for the UDP receive path.
// State encoding, header lengths, protocol constants, CRC helpers.
package udp_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_ETH_HDR,
        ST_IP_HDR,
        ST_UDP_HDR,
        ST_PAYLOAD,
        ST_TRAILER,
        ST_DROP
    } state_t;

    localparam logic [10:0] ETH_HDR_LEN = 11'd14;
    localparam logic [10:0] IP_HDR_LEN  = 11'd20;
    localparam logic [10:0] UDP_HDR_LEN = 11'd8;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  PRE_BYTE       = 8'h55;
    localparam logic [7:0]  SFD            = 8'hD5;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    // The CRC register shifts LSB first; the residue constant
    // is written in the normal (MSB-first) bit order.
    function automatic logic [31:0] bit_rev32(
        input logic [31:0] v
    );
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// eth_crc32_byte: combinational reflected CRC-32 step over one byte.
// Ports: crc (current), data (byte, LSB first on wire), crc_next.
module eth_crc32_byte
    import udp_rx_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    always_comb begin
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_next = c;
    end

endmodule

// File: rtl/udp_rx_packet.sv
// udp_rx_packet: filters Eth/IPv4/UDP frames and streams the payload.
// Ports: clk, rst (sync, active-high); packet_in_valid/data in;
// udp_rx_valid/data/last payload; src_mac/ip/port, len metadata;
// udp_rx_good/err status pulses.
// Optional: define UDP_RX_FCS_CHECK_EN to qualify good/err on FCS.
module udp_rx_packet
    import udp_rx_pkg::*;
#(
    parameter logic [47:0] our_mac  = 48'h2301EFBEADDE,
    parameter logic [31:0] our_ip   = 32'h4001A4C0,
    parameter logic [15:0] our_port = 16'h1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        packet_in_valid,
    input  logic [7:0]  packet_in_data,
    output logic        udp_rx_valid,
    output logic [7:0]  udp_rx_data,
    output logic        udp_rx_last,
    output logic [47:0] udp_rx_src_mac,
    output logic [31:0] udp_rx_src_ip,
    output logic [15:0] udp_rx_src_port,
    output logic [15:0] udp_rx_len,
    output logic        udp_rx_good,
    output logic        udp_rx_err
);

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [39:0] sh_q;
    logic [47:0] win;
    logic [15:0] hw;
    logic        len_bad;

    logic [47:0] smac_q;
    logic [31:0] sip_q;
    logic [15:0] sport_q;
    logic [15:0] iplen_q;
    logic [15:0] plen_q;

    logic fwd, last_hit, trunc, hdr_zero;
    logic lat_smac, lat_sip, lat_sport;
    logic lat_iplen, lat_ulen;
    logic good_d, err_d, zero_ok, meta_ld;

    // win: last six bytes, first wire byte in [7:0].
    // hw: last two bytes as a big-endian number.
    assign win = {packet_in_data, sh_q};
    assign hw  = {sh_q[39:32], packet_in_data};

    assign len_bad = (hw < 16'd8) ||
        ({1'b0, hw} + 17'd20 > {1'b0, iplen_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (packet_in_valid) begin
                sh_q <= win[47:8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 11'd1;
        fwd       = 1'b0;
        last_hit  = 1'b0;
        trunc     = 1'b0;
        hdr_zero  = 1'b0;
        lat_smac  = 1'b0;
        lat_sip   = 1'b0;
        lat_sport = 1'b0;
        lat_iplen = 1'b0;
        lat_ulen  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (packet_in_valid) begin
                    unique case (1'b1)
                        packet_in_data == PRE_BYTE:
                            state_d = ST_PREAMBLE;
                        packet_in_data == SFD:
                            state_d = ST_ETH_HDR;
                        default:
                            state_d = ST_DROP;
                    endcase
                end
            end
            ST_PREAMBLE: begin
                if (!packet_in_valid) begin
                    state_d = ST_IDLE;
                end else if (packet_in_data == SFD) begin
                    state_d = ST_ETH_HDR;
                end else if (packet_in_data != PRE_BYTE) begin
                    state_d = ST_DROP;
                end
            end
            ST_ETH_HDR: begin
                if (!packet_in_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q == 11'd5 && win != our_mac &&
                        win != '1) begin
                        state_d = ST_DROP;
                    end
                    if (cnt_q == 11'd11) begin
                        lat_smac = 1'b1;
                    end
                    if (cnt_q == ETH_HDR_LEN - 11'd1) begin
                        state_d = (hw == ETHERTYPE_IPV4) ?
                            ST_IP_HDR : ST_DROP;
                    end
                end
            end
            ST_IP_HDR: begin
                if (!packet_in_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q == 11'd0 &&
                        packet_in_data != IP_VER_IHL) begin
                        state_d = ST_DROP;
                    end
                    if (cnt_q == 11'd3) begin
                        lat_iplen = 1'b1;
                    end
                    if (cnt_q == 11'd9 &&
                        packet_in_data != IP_PROTO_UDP) begin
                        state_d = ST_DROP;
                    end
                    if (cnt_q == 11'd15) begin
                        lat_sip = 1'b1;
                    end
                    if (cnt_q == IP_HDR_LEN - 11'd1) begin
                        state_d = (win[47:16] == our_ip ||
                                   win[47:16] == '1) ?
                            ST_UDP_HDR : ST_DROP;
                    end
                end
            end
            ST_UDP_HDR: begin
                if (!packet_in_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q == 11'd1) begin
                        lat_sport = 1'b1;
                    end
                    if (cnt_q == 11'd3 && hw != our_port) begin
                        state_d = ST_DROP;
                    end
                    if (cnt_q == 11'd5) begin
                        lat_ulen = 1'b1;
                        if (len_bad) begin
                            state_d = ST_DROP;
                        end
                    end
                    if (cnt_q == UDP_HDR_LEN - 11'd1) begin
                        if (plen_q == 16'd0) begin
                            hdr_zero = 1'b1;
                            state_d  = ST_TRAILER;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!packet_in_valid) begin
                    trunc   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    fwd = 1'b1;
                    if ({5'd0, cnt_q} == plen_q - 16'd1) begin
                        last_hit = 1'b1;
                        state_d  = ST_TRAILER;
                    end
                end
            end
            ST_TRAILER, ST_DROP: begin
                if (!packet_in_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smac_q  <= '0;
            sip_q   <= '0;
            sport_q <= '0;
            iplen_q <= '0;
            plen_q  <= '0;
        end else begin
            if (lat_smac)  smac_q  <= win;
            if (lat_sip)   sip_q   <= win[47:16];
            if (lat_sport) sport_q <= hw;
            if (lat_iplen) iplen_q <= hw;
            if (lat_ulen)  plen_q  <= hw - 16'd8;
        end
    end

`ifdef UDP_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_nx;
    logic        fcs_end, crc_ok, zero_q;

    eth_crc32_byte u_crc (
        .crc      (crc_q),
        .data     (packet_in_data),
        .crc_next (crc_nx)
    );

    // Seeded on the SFD so the first dst MAC byte sees the init value.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q  <= '1;
            zero_q <= 1'b0;
        end else begin
            if (state_d == ST_ETH_HDR &&
                state_q != ST_ETH_HDR) begin
                crc_q <= '1;
            end else if (packet_in_valid) begin
                crc_q <= crc_nx;
            end
            if (state_q == ST_IDLE) begin
                zero_q <= 1'b0;
            end else if (hdr_zero) begin
                zero_q <= 1'b1;
            end
        end
    end

    assign fcs_end = (state_q == ST_TRAILER) && !packet_in_valid;
    assign crc_ok  = bit_rev32(crc_q) == CRC_RESIDUE;
    assign good_d  = fcs_end && crc_ok;
    assign err_d   = trunc || (fcs_end && !crc_ok);
    assign zero_ok = good_d && zero_q;
`else
    assign good_d  = last_hit || hdr_zero;
    assign err_d   = trunc;
    assign zero_ok = hdr_zero;
`endif

    assign meta_ld = (fwd && cnt_q == 11'd0) || zero_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            udp_rx_valid    <= 1'b0;
            udp_rx_data     <= '0;
            udp_rx_last     <= 1'b0;
            udp_rx_src_mac  <= '0;
            udp_rx_src_ip   <= '0;
            udp_rx_src_port <= '0;
            udp_rx_len      <= '0;
            udp_rx_good     <= 1'b0;
            udp_rx_err      <= 1'b0;
        end else begin
            udp_rx_valid <= fwd;
            udp_rx_last  <= last_hit;
            udp_rx_good  <= good_d;
            udp_rx_err   <= err_d;
            if (fwd) begin
                udp_rx_data <= packet_in_data;
            end
            if (meta_ld) begin
                udp_rx_src_mac  <= smac_q;
                udp_rx_src_ip   <= sip_q;
                udp_rx_src_port <= sport_q;
                udp_rx_len      <= plen_q;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_packet.sv
// tb_udp_rx_packet: table-driven frame vectors plus reset corner case.
// Builds whole frames (with FCS), checks payload, meta and pulses.
module tb_udp_rx_packet;

    localparam logic [47:0] OUR_MAC = 48'h2301EFBEADDE;
    localparam logic [31:0] OUR_IP  = 32'h4001A4C0;
    localparam logic [47:0] SRC_MAC = 48'h665544332211;
    localparam logic [31:0] SRC_IP  = 32'h0201A8C0;
    localparam logic [15:0] SRC_PRT = 16'hABCD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        packet_in_valid = 1'b0;
    logic [7:0]  packet_in_data = 8'h00;
    logic        udp_rx_valid;
    logic [7:0]  udp_rx_data;
    logic        udp_rx_last;
    logic [47:0] udp_rx_src_mac;
    logic [31:0] udp_rx_src_ip;
    logic [15:0] udp_rx_src_port;
    logic [15:0] udp_rx_len;
    logic        udp_rx_good;
    logic        udp_rx_err;

    udp_rx_packet dut (
        .clk             (clk),
        .rst             (rst),
        .packet_in_valid (packet_in_valid),
        .packet_in_data  (packet_in_data),
        .udp_rx_valid    (udp_rx_valid),
        .udp_rx_data     (udp_rx_data),
        .udp_rx_last     (udp_rx_last),
        .udp_rx_src_mac  (udp_rx_src_mac),
        .udp_rx_src_ip   (udp_rx_src_ip),
        .udp_rx_src_port (udp_rx_src_port),
        .udp_rx_len      (udp_rx_len),
        .udp_rx_good     (udp_rx_good),
        .udp_rx_err      (udp_rx_err)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          dm;
        int          di;
        logic [15:0] dport;
        int          plen;
        int          ldelta;
        logic [7:0]  ver;
        int          trunc_at;
        bit          flip;
        logic [31:0] head;
        int          exp_n;
        int          exp_last;
        int          exp_good;
        int          exp_err;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] frm[$];
    logic [7:0] expq[$];
    logic [7:0] rxq[$];
    int pay_idx, pay_cyc, hdr_cyc, fall_cyc;
    int nlast, ngood, nerr, last_idx;
    int first_cyc, last_cyc, good_cyc, err_cyc;
    int total = 0;
    int bad = 0;
    logic [15:0] acc_len = 16'h0;

    always @(negedge clk) begin
        if (udp_rx_valid) begin
            if (rxq.size() == 0) first_cyc = cyc;
            rxq.push_back(udp_rx_data);
        end
        if (udp_rx_last) begin
            nlast++;
            last_idx = rxq.size() - 1;
            last_cyc = cyc;
        end
        if (udp_rx_good) begin
            ngood++;
            good_cyc = cyc;
        end
        if (udp_rx_err) begin
            nerr++;
            err_cyc = cyc;
        end
    end

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h",
                     nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        int dm, int di, logic [15:0] dp, int pl, int ld,
        logic [7:0] ver, int tr, bit fl, logic [31:0] hd,
        int en, int el, int eg, int ee);
        vec_t v;
        v.dm = dm; v.di = di; v.dport = dp;
        v.plen = pl; v.ldelta = ld; v.ver = ver;
        v.trunc_at = tr; v.flip = fl; v.head = hd;
        v.exp_n = en; v.exp_last = el;
        v.exp_good = eg; v.exp_err = ee;
        return v;
    endfunction

    function automatic logic [7:0] pay(
        logic [31:0] hd, int i);
        if (i < 4) return hd[31-8*i -: 8];
        return 8'(8'h10 + i);
    endfunction

    function automatic logic [31:0] crc_step(
        logic [31:0] c, logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
            else c = c >> 1;
        end
        return c;
    endfunction

    task automatic put(input logic [7:0] b);
        frm.push_back(b);
    endtask

    task automatic build(input vec_t v);
        logic [47:0] dmac;
        logic [31:0] dip;
        logic [15:0] tot;
        logic [15:0] ul;
        logic [31:0] crc;
        logic [7:0]  b;
        frm.delete();
        expq.delete();
        dmac = (v.dm == 0) ? OUR_MAC :
               (v.dm == 1) ? 48'hFFFF_FFFF_FFFF :
                             48'h2401EFBEADDE;
        dip  = (v.di == 0) ? OUR_IP :
               (v.di == 1) ? 32'hFFFF_FFFF :
                             32'h4101A4C0;
        for (int i = 0; i < 7; i++) put(8'h55);
        put(8'hD5);
        for (int i = 0; i < 6; i++) put(dmac[8*i +: 8]);
        for (int i = 0; i < 6; i++) put(SRC_MAC[8*i +: 8]);
        put(8'h08); put(8'h00);
        tot = 16'(28 + v.plen);
        put(v.ver); put(8'h00);
        put(tot[15:8]); put(tot[7:0]);
        for (int i = 0; i < 4; i++) put(8'h00);
        put(8'h40); put(8'h11); put(8'h00); put(8'h00);
        for (int i = 0; i < 4; i++) put(SRC_IP[8*i +: 8]);
        for (int i = 0; i < 4; i++) put(dip[8*i +: 8]);
        put(SRC_PRT[15:8]); put(SRC_PRT[7:0]);
        put(v.dport[15:8]); put(v.dport[7:0]);
        ul = 16'(8 + v.plen + v.ldelta);
        put(ul[15:8]); put(ul[7:0]);
        put(8'h00); put(8'h00);
        pay_idx = frm.size();
        for (int i = 0; i < v.plen; i++) begin
            b = pay(v.head, i);
            put(b);
            if (i < v.exp_n) expq.push_back(b);
        end
        for (int i = 28 + v.plen; i < 46; i++) put(8'h00);
        crc = 32'hFFFF_FFFF;
        for (int i = 8; i < frm.size(); i++) begin
            crc = crc_step(crc, frm[i]);
        end
        crc = ~crc;
        if (v.flip) crc[5] = ~crc[5];
        for (int i = 0; i < 4; i++) put(crc[8*i +: 8]);
    endtask

    task automatic clear_mon();
        rxq.delete();
        nlast = 0; ngood = 0; nerr = 0;
        last_idx = -1; first_cyc = -1; last_cyc = -1;
        good_cyc = -1; err_cyc = -1;
    endtask

    task automatic send(input int trunc_at, input int rst_at);
        int n;
        n = frm.size();
        if (trunc_at >= 0) n = pay_idx + trunc_at;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = (rst_at >= 0 && i == pay_idx + rst_at);
            packet_in_valid = 1'b1;
            packet_in_data  = frm[i];
            if (i == pay_idx) pay_cyc = cyc;
            if (i == pay_idx - 1) hdr_cyc = cyc;
            if (rst_at >= 0 && i == pay_idx + rst_at + 1) begin
                @(negedge clk);
                chk("rst_outs",
                    {udp_rx_valid, udp_rx_last, udp_rx_good,
                     udp_rx_err, udp_rx_data, udp_rx_len,
                     udp_rx_src_port}, 64'h0);
                chk("rst_meta",
                    {udp_rx_src_mac, udp_rx_src_ip[15:0]},
                    64'h0);
                chk("rst_ip", udp_rx_src_ip, 64'h0);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        packet_in_valid = 1'b0;
        packet_in_data  = 8'h00;
        fall_cyc = cyc;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input vec_t v);
        int diffs;
        diffs = 0;
        chk("nbytes", rxq.size(), v.exp_n);
        for (int i = 0; i < rxq.size() && i < expq.size();
             i++) begin
            if (rxq[i] !== expq[i]) diffs++;
        end
        chk("bytes", diffs, 0);
        chk("nlast", nlast, v.exp_last);
        if (v.exp_last != 0) chk("last_pos", last_idx, v.exp_n - 1);
        chk("ngood", ngood, v.exp_good);
        chk("nerr", nerr, v.exp_err);
        if (v.exp_n > 0 || v.exp_good != 0) begin
            acc_len = 16'(v.plen + v.ldelta);
            chk("src_mac", udp_rx_src_mac, SRC_MAC);
            chk("src_ip", udp_rx_src_ip, SRC_IP);
            chk("src_port", udp_rx_src_port, SRC_PRT);
        end
        chk("len", udp_rx_len, acc_len);
        if (v.exp_n > 0) chk("latency", first_cyc, pay_cyc + 1);
        if (v.exp_err != 0) chk("err_time", err_cyc, fall_cyc + 1);
        if (v.exp_good != 0) begin
`ifdef UDP_RX_FCS_CHECK_EN
            chk("good_time", good_cyc, fall_cyc + 1);
`else
            if (v.exp_n > 0) chk("good_time", good_cyc, last_cyc);
            else chk("good_time", good_cyc, hdr_cyc + 1);
`endif
        end
    endtask

    initial begin
        vec_t vr;
        vecs.push_back(mk(0,0,16'h1000,4,0,8'h45,-1,0,
                          32'hDEADBEEF,4,1,1,0));
        vecs.push_back(mk(0,0,16'h1001,4,0,8'h45,-1,0,
                          32'hDEADBEEF,0,0,0,0));
        vecs.push_back(mk(0,0,16'h1000,4,0,8'h45,-1,0,
                          32'h11223344,4,1,1,0));
        vecs.push_back(mk(1,1,16'h1000,18,0,8'h45,-1,0,
                          32'hA1A2A3A4,18,1,1,0));
        vecs.push_back(mk(0,0,16'h1000,1,0,8'h45,-1,0,
                          32'h5A000000,1,1,1,0));
        vecs.push_back(mk(0,0,16'h1000,10,0,8'h45,2,0,
                          32'hC0C1C2C3,2,0,0,1));
        vecs.push_back(mk(0,0,16'h1000,0,0,8'h45,-1,0,
                          32'h0,0,0,1,0));
        vecs.push_back(mk(2,0,16'h1000,4,0,8'h45,-1,0,
                          32'h01020304,0,0,0,0));
        vecs.push_back(mk(0,2,16'h1000,4,0,8'h45,-1,0,
                          32'h01020304,0,0,0,0));
        vecs.push_back(mk(0,0,16'h1000,4,1,8'h45,-1,0,
                          32'h01020304,0,0,0,0));
        vecs.push_back(mk(0,0,16'h1000,0,-1,8'h45,-1,0,
                          32'h0,0,0,0,0));
        vecs.push_back(mk(0,0,16'h1000,4,0,8'h46,-1,0,
                          32'h01020304,0,0,0,0));
        vecs.push_back(mk(0,0,16'h1000,4,-1,8'h45,-1,0,
                          32'h31323334,3,1,1,0));
`ifdef UDP_RX_FCS_CHECK_EN
        vecs.push_back(mk(0,0,16'h1000,4,0,8'h45,-1,1,
                          32'h41424344,4,1,0,1));
`else
        vecs.push_back(mk(0,0,16'h1000,4,0,8'h45,-1,1,
                          32'h41424344,4,1,1,0));
`endif

        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs",
            {udp_rx_valid, udp_rx_last, udp_rx_good,
             udp_rx_err, udp_rx_data, udp_rx_len,
             udp_rx_src_port}, 64'h0);
        chk("reset_meta", udp_rx_src_mac, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            clear_mon();
            build(vecs[k]);
            send(vecs[k].trunc_at, -1);
            check_frame(vecs[k]);
        end

        vr = mk(0,0,16'h1000,10,0,8'h45,-1,0,
                32'h01020304,2,0,0,0);
        clear_mon();
        build(vr);
        send(-1, 2);
        acc_len = 16'h0;
        chk("rst_nbytes", rxq.size(), 2);
        chk("rst_nlast", nlast, 0);
        chk("rst_ngood", ngood, 0);
        chk("rst_nerr", nerr, 0);
        chk("rst_len", udp_rx_len, acc_len);

        clear_mon();
        build(vecs[0]);
        send(-1, -1);
        check_frame(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udp_rx_packet.md
Name: udp_rx_packet

Overview:
Receive-side counterpart of the UDP packet generator. It consumes the byte stream from the RGMII RX interface, which carries preamble, SFD, Ethernet, IPv4, UDP, payload and FCS. It checks the headers against the local MAC, IP and port, then streams the UDP payload bytes out with header metadata and an end-of-packet status pulse. It sits between the RX interface and user logic in the 125 MHz domain.

Parameters:
our_mac, 48'h2301EFBEADDE, local MAC; the first wire byte is in bits [7:0].
our_ip, 32'h4001A4C0, local IPv4 address; the first wire byte is in bits [7:0].
our_port, 16'h1000, accepted UDP destination port; numeric value, wire order is MSB first.

Ports:
clk  in  1  125 MHz clock
rst  in  1  synchronous, active-high reset
packet_in_valid  in  1  high for every byte of a frame, contiguous, low between frames
packet_in_data  in  8  frame byte in wire order
udp_rx_valid  out  1  payload byte valid
udp_rx_data  out  8  payload byte
udp_rx_last  out  1  high with the final payload byte
udp_rx_src_mac  out  48  sender MAC, byte 0 in [7:0]
udp_rx_src_ip  out  32  sender IP, byte 0 in [7:0]
udp_rx_src_port  out  16  sender UDP port, numeric
udp_rx_len  out  16  payload length in bytes (UDP length − 8)
udp_rx_good  out  1  one-cycle pulse: packet accepted and complete
udp_rx_err  out  1  one-cycle pulse: accepted packet was truncated or had a bad FCS

Behaviour:
- Clocking and reset: one clock (clk); synchronous, active-high reset (rst).
- Reset values: all outputs 0; state IDLE; counters 0.
- States:
  - IDLE: wait for packet_in_valid.
  - PREAMBLE: skip 0x55 bytes; on 0xD5 go to ETH_HDR; on any other byte go to DROP.
  - ETH_HDR (14 bytes): dst MAC must equal our_mac or FF:FF:FF:FF:FF:FF; latch src MAC; EtherType must be 0x0800.
  - IP_HDR (20 bytes): byte 0 must be 0x45 (options unsupported, so drop); protocol must be 17; latch src IP; dst IP must equal our_ip or 0xFFFFFFFF; latch total length. IP checksum is not checked.
  - UDP_HDR (8 bytes): latch src port; dst port must equal our_port; latch UDP length L. Drop if L<8 or L>IPtotal−20.
  - PAYLOAD: forward L−8 bytes.
  - TRAILER: swallow padding and FCS until valid goes low, then go to IDLE.
  - DROP: ignore all input until valid goes low, then go to IDLE; no outputs.
- Filter checks are made on the byte where each field completes. Any mismatch goes to DROP on the next cycle.
- Byte counter is 11 bits and is reset on each state entry.
- Latency: each payload byte appears on udp_rx_data one cycle after it is sampled.
- udp_rx_last accompanies the (L−8)th byte.
- Metadata outputs update on the cycle of the first payload byte, or with udp_rx_good when L=8, and hold until the next accepted packet.
- Zero payload (L=8): no udp_rx_valid; udp_rx_good is still produced.
- Without the optional feature, udp_rx_good pulses in the same cycle as udp_rx_last (or one cycle after the last UDP header byte when L=8).
- Truncation: if packet_in_valid falls during PAYLOAD, udp_rx_err pulses on the next cycle and udp_rx_last is never asserted; the state returns to IDLE. Truncation before PAYLOAD drops the frame silently.
- A new frame starting while in TRAILER or DROP is impossible, because valid must first go low.
- Reset mid-frame: outputs go to 0 on the next cycle and the state returns to IDLE. Any remaining bytes of that frame are processed from IDLE (preamble check fails, so DROP).

Optional Feature:
UDP_RX_FCS_CHECK_EN
- Defined: a CRC-32 (reflected, poly 0x04C11DB7, init 0xFFFFFFFF) runs over every byte from the first dst MAC byte to the end of the FCS.
  - At valid fall in TRAILER, the residue must be 0xC704DD7B: pulse udp_rx_good, otherwise pulse udp_rx_err.
  - udp_rx_good is therefore not issued with udp_rx_last; it is issued at end of frame.
  - Payload is still streamed live, so consumers must discard on udp_rx_err.
- Undefined: no CRC logic; timing of udp_rx_good is as described in Behaviour.

Decomposition:
- Package udp_rx_pkg holds:
  - state enum;
  - header byte-count constants (ETH_HDR_LEN=14, IP_HDR_LEN=20, UDP_HDR_LEN=8);
  - ETHERTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'd17, IP_VER_IHL=8'h45, SFD=8'hD5, CRC_RESIDUE.
- Sub-module eth_crc32_byte (combinational next-CRC for one byte, registered by the parent) is instantiated only under UDP_RX_FCS_CHECK_EN.

Test Plan:
- Unicast frame to our_mac/our_ip, port 0x1000, payload DE AD BE EF -> 4 valid bytes in order, last on EF, udp_rx_len=4, src_port latched, good pulse, err=0.
- Same frame with dst port 0x1001 -> no valid, no good, no err; the following correct frame is accepted normally.
- Broadcast MAC/IP, 18-byte payload (no pad) -> accepted; a 1-byte payload padded to 46 bytes -> single byte with last, padding is not output.
- packet_in_valid drops after 2 of 10 payload bytes -> 2 valid bytes, no last, err pulse one cycle after valid falls.
- UDP length 8 -> no valid, one good pulse, udp_rx_len=0.
- With UDP_RX_FCS_CHECK_EN: correct FCS -> good at end of frame; one FCS bit flipped -> err. Reset asserted mid-payload -> all outputs 0 next cycle, and the next clean frame is accepted.
